// File: rtl/pipe_pkg.sv
// Shared types for the decode-stage hazard unit: scoreboard entry layout and
// forward-select encoding.
package pipe_pkg;

  localparam int REG_W_MAX   = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic                 valid;
    logic                 wr;
    logic                 is_load;
    logic [REG_W_MAX-1:0] dst;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{valid: 1'b0, wr: 1'b0, is_load: 1'b0,
                                     dst: {REG_W_MAX{1'b0}}};

  // Scoreboard entry k carries the result that stage k produces.
  function automatic int fwd_code(input int stage);
    return stage + 1;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-source match against the scoreboard: youngest forwardable producer
// and load-use detection against the entry in EX.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int NSTAGES  = 3,
  parameter int REG_W    = 4,
  parameter int ZERO_REG = 1,
  parameter int SEL_W    = 2
) (
  input  sb_entry_t [NSTAGES-1:0] sb,
  input  logic [REG_W-1:0]        src,
  input  logic                    src_used,
  input  logic                    id_valid,
  output logic [SEL_W-1:0]        fwd_sel,
  output logic                    load_hit
);

  logic [REG_W_MAX-1:0] src_ext;
  logic                 zero_src;
  logic                 src_live;
  logic [NSTAGES-1:0]   match;

  assign src_ext  = REG_W_MAX'(src);
  assign zero_src = (ZERO_REG != 0) && (src == {REG_W{1'b0}});
  assign src_live = id_valid & src_used & ~zero_src;

  // Priority pick: the lowest-index match wins; a load in EX has no result yet.
  always_comb begin
    match    = {NSTAGES{1'b0}};
    fwd_sel  = SEL_W'(FWD_REGFILE);
    load_hit = 1'b0;
    for (int k = 0; k < NSTAGES; k++) begin
      match[k] = src_live & sb[k].valid & sb[k].wr & (sb[k].dst == src_ext)
                 & ~((k == 0) & sb[k].is_load);
    end
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      fwd_sel = match[k] ? SEL_W'(fwd_code(k)) : fwd_sel;
    end
    load_hit = src_live & sb[0].valid & sb[0].wr & sb[0].is_load
               & (sb[0].dst == src_ext);
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Decode-stage hazard unit: scoreboard of in-flight writers, load-use stall,
// branch flush, forward selects and saturating stall/flush counters.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int NSTAGES  = 3,
  parameter int REG_W    = 4,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             id_valid,
  input  logic [REG_W-1:0]                 id_src1,
  input  logic [REG_W-1:0]                 id_src2,
  input  logic                             id_src1_used,
  input  logic                             id_src2_used,
  input  logic [REG_W-1:0]                 id_dst,
  input  logic                             id_wr,
  input  logic                             id_is_load,
  input  logic                             br_taken,
  input  logic                             ext_stall,
  output logic                             stall_if,
  output logic                             stall_id,
  output logic                             flush_id,
  output logic                             bubble_ex,
  output logic [$clog2(NSTAGES+1)-1:0]     fwd_sel1,
  output logic [$clog2(NSTAGES+1)-1:0]     fwd_sel2,
  output logic [NSTAGES-1:0]               stage_valid,
  output logic [CNT_W-1:0]                 stall_cnt,
  output logic [CNT_W-1:0]                 flush_cnt
);

  localparam int SEL_W = $clog2(NSTAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  sb_entry_t [NSTAGES-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]        flush_cnt_q, flush_cnt_d;
  logic                    hit1, hit2, load_use;

  hazard_match #(.NSTAGES(NSTAGES), .REG_W(REG_W), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W))
  u_match1 (.sb(sb_q), .src(id_src1), .src_used(id_src1_used), .id_valid(id_valid),
            .fwd_sel(fwd_sel1), .load_hit(hit1));

  hazard_match #(.NSTAGES(NSTAGES), .REG_W(REG_W), .ZERO_REG(ZERO_REG), .SEL_W(SEL_W))
  u_match2 (.sb(sb_q), .src(id_src2), .src_used(id_src2_used), .id_valid(id_valid),
            .fwd_sel(fwd_sel2), .load_hit(hit2));

  assign load_use  = hit1 | hit2;
  assign stall_if  = ext_stall | load_use;
  assign stall_id  = ext_stall | load_use;
  assign bubble_ex = load_use & ~ext_stall;
  assign flush_id  = br_taken & id_valid & ~load_use & ~ext_stall;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Expose the valid bit of every tracked stage.
  always_comb begin
    stage_valid = {NSTAGES{1'b0}};
    for (int k = 0; k < NSTAGES; k++) begin
      stage_valid[k] = sb_q[k].valid;
    end
  end

  // Advance the scoreboard and counters unless frozen; a load-use bubble enters EX.
  always_comb begin
    sb_d        = sb_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (ext_stall) begin
      sb_d = sb_q;
    end else begin
      for (int k = NSTAGES - 1; k >= 1; k--) begin
        sb_d[k] = sb_q[k-1];
      end
      if (id_valid && !load_use) begin
        sb_d[0] = '{valid: 1'b1, wr: id_wr, is_load: id_is_load,
                    dst: REG_W_MAX'(id_dst)};
      end else begin
        sb_d[0] = SB_EMPTY;
      end
      if (load_use && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (flush_id && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTAGES; k++) begin
        sb_q[k] <= SB_EMPTY;
      end
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
